silu_lut_scheduler: RTL and testbench
=====================================

Name: silu_lut_scheduler

Overview:
- Time-multiplexes NUM_LUT instances of the 3-bit silu_lut activation table over an IN_SIZE-element input vector.
- Sits between an upstream valid/ready vector stream and the downstream consumer.
- Serializes the captured vector through the shared LUTs in IN_SIZE/NUM_LUT beats, reassembles the results, and presents one output vector per input vector.
- Saves LUT area versus one table per element.

Parameters:
DATA_WIDTH, 3, element width; fixed to the silu_lut table width, elaboration error otherwise
IN_SIZE, 4, elements per vector
NUM_LUT, 1, LUT instances used per beat; IN_SIZE % NUM_LUT must be 0, elaboration error otherwise

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
data_in_0  in  IN_SIZE*DATA_WIDTH  input vector; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
data_in_0_valid  in  1  input vector valid
data_in_0_ready  out  1  scheduler can accept a vector
data_out_0  out  IN_SIZE*DATA_WIDTH  result vector, same packing as input
data_out_0_valid  out  1  result vector valid
data_out_0_ready  in  1  downstream accepts result
busy  out  1  high in RUN (and FLUSH when enabled)

Behaviour:
- BEATS = IN_SIZE/NUM_LUT. idx is a counter of width clog2(BEATS), minimum 1 bit.
- Reset (rst=0 at a clock edge) gives: state=IDLE, idx=0, data_out_0 register=0, data_out_0_valid=0, busy=0. The captured input register is don't-care.
- Reset asserted mid-RUN or mid-DONE discards the vector in flight. No output is produced for it.
- IDLE:
  - data_in_0_ready=1.
  - On data_in_0_valid: capture data_in_0, set idx=0, go RUN.
- RUN:
  - data_in_0_ready=0, busy=1.
  - Each cycle, LUT k (k=0..NUM_LUT-1) looks up captured element idx*NUM_LUT+k.
  - The result is written to the same element slot of the output register.
  - idx increments by 1.
  - On the beat where idx=BEATS-1: idx wraps to 0, go DONE.
- DONE:
  - data_out_0_valid=1. data_out_0 is held stable until the handshake completes.
  - On data_out_0_ready: deassert valid.
  - data_in_0_ready = data_out_0_ready in DONE, a combinational path permitted only in this state.
  - Output fire with input valid present: capture the new vector and go RUN in the same cycle (back-to-back).
  - Output fire without input valid: go IDLE.
- Latency: an input accepted at edge T produces data_out_0_valid at edge T+BEATS. Throughput is one vector per BEATS+1 cycles with zero backpressure.
- Element mapping matches silu_lut exactly: 0→0, 1→1, 2→2, 3→3, 4..7→0.
- data_out_0 register is not cleared between vectors. Every slot is overwritten during RUN.
- data_out_0_ready while not in DONE is ignored.
- data_in_0_valid while not in IDLE or DONE is ignored. Upstream must hold data until ready.

Optional Feature:
- Macro: SILU_SCHED_PIPE_EN.
- Defined:
  - A register stage is inserted on each LUT output, with a valid flag and a slot index.
  - After the last RUN beat, state goes FLUSH for 1 cycle to write the final group, then DONE.
  - Latency becomes T+BEATS+1. Throughput is one vector per BEATS+2 cycles.
  - busy=1 in FLUSH. Reset also clears the pipe valid flag.
- Undefined: LUT output is written directly, as described above. There is no FLUSH state.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs → data_out_0_valid=0, data_out_0=0, data_in_0_ready=1 after release, busy=0.
- Basic (IN_SIZE=4, NUM_LUT=1): accept elements {e0..e3}={1,2,5,7} at edge T → valid at T+4, data_out_0 elements {1,2,0,0}, ready low during RUN.
- Backpressure: data_out_0_ready=0 for 5 cycles after valid, with input {3,4,0,6} → data_out_0 stable at {3,0,0,0}, valid held high, no new input accepted. Release ready → one fire, then IDLE.
- Back-to-back: second vector {7,6,5,3} offered while DONE with ready=1 → accepted on the fire cycle, second result {0,0,0,3} valid 4 edges later, no idle cycle between.
- Reset mid-RUN: assert rst at idx=2 → next cycle IDLE, valid=0. The following vector {2,2,2,2} yields {2,2,2,2} with normal latency.
- NUM_LUT=2 and SILU_SCHED_PIPE_EN: input {0,1,4,3} (IN_SIZE=4) → without macro valid at T+2; with macro valid at T+3. Both give output {0,1,0,3}.

Source files
------------

// File: rtl/silu_lut_scheduler_if.sv
// Vector stream bundle for silu_lut_scheduler: one upstream input channel and
// one downstream result channel.
interface silu_lut_scheduler_if #(
  parameter int DATA_WIDTH = 3,
  parameter int IN_SIZE    = 4
);
  // Handshake rule for both channels: a transfer happens on a rising edge where
  // valid and ready are both high; the sender holds data and valid until then.
  logic [IN_SIZE*DATA_WIDTH-1:0] data_in_0;
  logic                          data_in_0_valid;
  logic                          data_in_0_ready;
  logic [IN_SIZE*DATA_WIDTH-1:0] data_out_0;
  logic                          data_out_0_valid;
  logic                          data_out_0_ready;

  modport master (
    output data_in_0, data_in_0_valid, data_out_0_ready,
    input  data_in_0_ready, data_out_0, data_out_0_valid
  );

  modport slave (
    input  data_in_0, data_in_0_valid, data_out_0_ready,
    output data_in_0_ready, data_out_0, data_out_0_valid
  );
endinterface

// File: rtl/silu_lut_scheduler.sv
// Shares NUM_LUT 3-bit silu tables across an IN_SIZE-element vector over
// IN_SIZE/NUM_LUT beats. Define SILU_SCHED_PIPE_EN to register the LUT outputs.
module silu_lut_scheduler #(
  parameter int DATA_WIDTH = 3,
  parameter int IN_SIZE    = 4,
  parameter int NUM_LUT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  silu_lut_scheduler_if.slave   bus,
  output logic                  busy,
  output logic [1:0]            state_o
);
  localparam int BEATS = IN_SIZE / NUM_LUT;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VW    = IN_SIZE * DATA_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  if (DATA_WIDTH != 3) begin : g_bad_width
    $error("silu_lut_scheduler: DATA_WIDTH must be 3");
  end
  if ((IN_SIZE % NUM_LUT) != 0) begin : g_bad_split
    $error("silu_lut_scheduler: IN_SIZE must be a multiple of NUM_LUT");
  end

  function automatic logic [DATA_WIDTH-1:0] silu_lut(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? '0 : x;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VW-1:0]    in_q, in_d;
  logic [VW-1:0]    out_q, out_d;
  logic             valid_q, valid_d;
  logic             last_beat;
  int               slot;

`ifdef SILU_SCHED_PIPE_EN
  logic                          pipe_valid_q, pipe_valid_d;
  logic [IDX_W-1:0]              pipe_idx_q, pipe_idx_d;
  logic [NUM_LUT*DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
`endif

  assign last_beat = (idx_q == IDX_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    in_d    = in_q;
    out_d   = out_q;
    valid_d = valid_q;
    slot    = 0;
`ifdef SILU_SCHED_PIPE_EN
    pipe_valid_d = pipe_valid_q;
    pipe_idx_d   = pipe_idx_q;
    pipe_data_d  = pipe_data_q;
    // Retire the group looked up on the previous beat before the new one lands.
    if (pipe_valid_q) begin
      for (int k = 0; k < NUM_LUT; k++) begin
        slot = int'(pipe_idx_q) * NUM_LUT + k;
        out_d[slot*DATA_WIDTH +: DATA_WIDTH] = pipe_data_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
      pipe_valid_d = 1'b0;
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.data_in_0_valid) begin
          in_d    = bus.data_in_0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NUM_LUT; k++) begin
          slot = int'(idx_q) * NUM_LUT + k;
`ifdef SILU_SCHED_PIPE_EN
          pipe_data_d[k*DATA_WIDTH +: DATA_WIDTH] = silu_lut(in_q[slot*DATA_WIDTH +: DATA_WIDTH]);
`else
          out_d[slot*DATA_WIDTH +: DATA_WIDTH] = silu_lut(in_q[slot*DATA_WIDTH +: DATA_WIDTH]);
`endif
        end
`ifdef SILU_SCHED_PIPE_EN
        pipe_idx_d   = idx_q;
        pipe_valid_d = 1'b1;
`endif
        idx_d = idx_q + 1'b1;
        if (last_beat) begin
          idx_d = '0;
`ifdef SILU_SCHED_PIPE_EN
          state_d = S_FLUSH;
`else
          state_d = S_DONE;
          valid_d = 1'b1;
`endif
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
        valid_d = 1'b1;
      end
      S_DONE: begin
        if (bus.data_out_0_ready) begin
          valid_d = 1'b0;
          if (bus.data_in_0_valid) begin
            in_d    = bus.data_in_0;
            idx_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
`ifdef SILU_SCHED_PIPE_EN
      pipe_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
`ifdef SILU_SCHED_PIPE_EN
      pipe_valid_q <= pipe_valid_d;
`endif
    end
  end

  // Captured vector and pipe payload are qualified by state/valid, so no reset.
  always_ff @(posedge clk) begin
    in_q <= in_d;
`ifdef SILU_SCHED_PIPE_EN
    pipe_idx_q  <= pipe_idx_d;
    pipe_data_q <= pipe_data_d;
`endif
  end

  assign bus.data_in_0_ready  = (state_q == S_IDLE) ||
                                ((state_q == S_DONE) && bus.data_out_0_ready);
  assign bus.data_out_0       = out_q;
  assign bus.data_out_0_valid = valid_q;
  assign busy                 = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign state_o              = state_q;
endmodule

// File: tb/tb_silu_lut_scheduler.sv
// Directed bench for silu_lut_scheduler: DUT a uses NUM_LUT=1, DUT b NUM_LUT=2.
module tb_silu_lut_scheduler;
  localparam int DW = 3;
  localparam int N  = 4;
`ifdef SILU_SCHED_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam int LAT_A = 4 + PIPE;
  localparam int LAT_B = 2 + PIPE;

  logic       clk;
  logic       rst;
  logic       busy_a, busy_b;
  logic [1:0] state_a, state_b;
  int         n_checks;
  int         n_errors;

  silu_lut_scheduler_if #(.DATA_WIDTH(DW), .IN_SIZE(N)) bus_a ();
  silu_lut_scheduler_if #(.DATA_WIDTH(DW), .IN_SIZE(N)) bus_b ();

  silu_lut_scheduler #(.DATA_WIDTH(DW), .IN_SIZE(N), .NUM_LUT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a), .state_o(state_a)
  );
  silu_lut_scheduler #(.DATA_WIDTH(DW), .IN_SIZE(N), .NUM_LUT(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .busy(busy_b), .state_o(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*DW-1:0] pack4(input logic [2:0] e0, input logic [2:0] e1,
                                           input logic [2:0] e2, input logic [2:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait out the fixed latency on DUT a: valid must stay low, then rise.
  task automatic wait_result_a(input string tag);
    for (int i = 1; i < LAT_A; i++) begin
      tick();
      check({tag, "_valid_low"}, 32'(bus_a.data_out_0_valid), 32'd0);
      check({tag, "_ready_low"}, 32'(bus_a.data_in_0_ready), 32'd0);
    end
    tick();
    check({tag, "_valid_high"}, 32'(bus_a.data_out_0_valid), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus_b.data_in_0 = '0;
    bus_b.data_in_0_valid = 1'b0;
    bus_b.data_out_0_ready = 1'b0;

    // Reset with random activity on DUT a inputs
    for (int i = 0; i < 3; i++) begin
      bus_a.data_in_0        = N*DW'($urandom_range(0, 4095));
      bus_a.data_in_0_valid  = 1'($urandom_range(0, 1));
      bus_a.data_out_0_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("rst_valid", 32'(bus_a.data_out_0_valid), 32'd0);
    check("rst_data",  32'(bus_a.data_out_0), 32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_state", 32'(state_a), 32'd0);
    check("rst_b_valid", 32'(bus_b.data_out_0_valid), 32'd0);
    rst = 1'b1;
    bus_a.data_in_0_valid  = 1'b0;
    bus_a.data_out_0_ready = 1'b0;
    #1;
    check("rst_ready", 32'(bus_a.data_in_0_ready), 32'd1);

    // Basic: {1,2,5,7} -> {1,2,0,0}
    bus_a.data_in_0 = pack4(3'd1, 3'd2, 3'd5, 3'd7);
    bus_a.data_in_0_valid = 1'b1;
    tick();
    bus_a.data_in_0_valid = 1'b0;
    check("basic_busy", 32'(busy_a), 32'd1);
    check("basic_run_ready", 32'(bus_a.data_in_0_ready), 32'd0);
    wait_result_a("basic");
    check("basic_data", 32'(bus_a.data_out_0), 32'(pack4(3'd1, 3'd2, 3'd0, 3'd0)));
    check("basic_done_busy", 32'(busy_a), 32'd0);
    bus_a.data_out_0_ready = 1'b1;
    #1;
    check("basic_done_ready", 32'(bus_a.data_in_0_ready), 32'd1);
    tick();
    check("basic_fire_valid", 32'(bus_a.data_out_0_valid), 32'd0);
    check("basic_idle", 32'(state_a), 32'd0);

    // Backpressure: {3,4,0,6} -> {3,0,0,0}, held for 5 cycles
    bus_a.data_out_0_ready = 1'b0;
    bus_a.data_in_0 = pack4(3'd3, 3'd4, 3'd0, 3'd6);
    bus_a.data_in_0_valid = 1'b1;
    tick();
    bus_a.data_in_0_valid = 1'b0;
    wait_result_a("bp");
    check("bp_data", 32'(bus_a.data_out_0), 32'(pack4(3'd3, 3'd0, 3'd0, 3'd0)));
    for (int i = 0; i < 5; i++) begin
      bus_a.data_in_0 = pack4(3'd1, 3'd1, 3'd1, 3'd1);
      bus_a.data_in_0_valid = 1'b1;
      #1;
      check("bp_in_ready", 32'(bus_a.data_in_0_ready), 32'd0);
      tick();
      check("bp_hold_valid", 32'(bus_a.data_out_0_valid), 32'd1);
      check("bp_hold_data", 32'(bus_a.data_out_0), 32'(pack4(3'd3, 3'd0, 3'd0, 3'd0)));
      check("bp_hold_state", 32'(state_a), 32'd2);
    end
    bus_a.data_in_0_valid = 1'b0;
    bus_a.data_out_0_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus_a.data_out_0_valid), 32'd0);
    check("bp_release_idle", 32'(state_a), 32'd0);

    // Back-to-back: {0,3,6,1} -> {0,3,0,1}, then {7,6,5,3} -> {0,0,0,3}
    bus_a.data_in_0 = pack4(3'd0, 3'd3, 3'd6, 3'd1);
    bus_a.data_in_0_valid = 1'b1;
    tick();
    bus_a.data_in_0 = pack4(3'd7, 3'd6, 3'd5, 3'd3);
    wait_result_a("b2b_first");
    check("b2b_first_data", 32'(bus_a.data_out_0), 32'(pack4(3'd0, 3'd3, 3'd0, 3'd1)));
    check("b2b_done_ready", 32'(bus_a.data_in_0_ready), 32'd1);
    tick();
    bus_a.data_in_0_valid = 1'b0;
    check("b2b_fire_valid", 32'(bus_a.data_out_0_valid), 32'd0);
    check("b2b_rerun_state", 32'(state_a), 32'd1);
    check("b2b_rerun_busy", 32'(busy_a), 32'd1);
    wait_result_a("b2b_second");
    check("b2b_second_data", 32'(bus_a.data_out_0), 32'(pack4(3'd0, 3'd0, 3'd0, 3'd3)));
    tick();
    check("b2b_idle", 32'(state_a), 32'd0);

    // Reset mid-RUN at idx=2 discards the vector
    bus_a.data_in_0 = pack4(3'd1, 3'd1, 3'd1, 3'd1);
    bus_a.data_in_0_valid = 1'b1;
    tick();
    bus_a.data_in_0_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_state", 32'(state_a), 32'd0);
    check("midrst_valid", 32'(bus_a.data_out_0_valid), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    bus_a.data_in_0 = pack4(3'd2, 3'd2, 3'd2, 3'd2);
    bus_a.data_in_0_valid = 1'b1;
    tick();
    bus_a.data_in_0_valid = 1'b0;
    wait_result_a("midrst_next");
    check("midrst_next_data", 32'(bus_a.data_out_0), 32'(pack4(3'd2, 3'd2, 3'd2, 3'd2)));
    tick();
    check("midrst_next_idle", 32'(state_a), 32'd0);

    // NUM_LUT=2: {0,1,4,3} -> {0,1,0,3}
    bus_b.data_out_0_ready = 1'b1;
    bus_b.data_in_0 = pack4(3'd0, 3'd1, 3'd4, 3'd3);
    bus_b.data_in_0_valid = 1'b1;
    #1;
    check("b_idle_ready", 32'(bus_b.data_in_0_ready), 32'd1);
    tick();
    bus_b.data_in_0_valid = 1'b0;
    check("b_busy", 32'(busy_b), 32'd1);
    for (int i = 1; i < LAT_B; i++) begin
      tick();
      check("b_valid_low", 32'(bus_b.data_out_0_valid), 32'd0);
    end
    tick();
    check("b_valid_high", 32'(bus_b.data_out_0_valid), 32'd1);
    check("b_data", 32'(bus_b.data_out_0), 32'(pack4(3'd0, 3'd1, 3'd0, 3'd3)));
    tick();
    check("b_fire_valid", 32'(bus_b.data_out_0_valid), 32'd0);
    check("b_idle", 32'(state_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
